// File: rtl/sub_bytes_pipe.sv
// Pipelined multi-lane AES SubBytes / InvSubBytes with valid/ready on both sides.
// Each lane evaluates the S-box as GF(2^8) inversion combined with the AES affine map.
module sub_bytes_pipe #(
  parameter int LANES = 4,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic [CNT_W-1:0]   beats_done
);
  localparam int W = 8*LANES;

  // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
    return inv ? gf_inv(affine_inv(x)) : affine_fwd(gf_inv(x));
  endfunction

  logic         adv_b;
  logic [W-1:0] look_src;
  logic         inv_src;
  logic         vld_src;
  logic [W-1:0] look_res;

  assign adv_b = !out_valid || out_ready;

  generate
    if (LAT >= 2) begin : g_lat2
      logic [W-1:0] data_p0;
      logic         inv_p0;
      logic         vld_p0;
      logic         adv_a;

      assign adv_a    = !vld_p0 || adv_b;
      assign in_ready = !rst && adv_a;

      // Stage A: input register
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p0 <= 1'b0;
        end else if (adv_a) begin
          vld_p0 <= in_valid && in_ready;
        end
      end

      always_ff @(posedge clk) begin
        if (adv_a && in_valid) begin
          data_p0 <= in_data;
          inv_p0  <= in_inv;
        end
      end

      assign look_src = data_p0;
      assign inv_src  = inv_p0;
      assign vld_src  = vld_p0;
    end else begin : g_lat1
      assign in_ready = !rst && adv_b;
      assign look_src = in_data;
      assign inv_src  = in_inv;
      assign vld_src  = in_valid && in_ready;
    end
  endgenerate

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign look_res[8*l +: 8] = sub_byte(look_src[8*l +: 8], inv_src);
    end
  endgenerate

  // Stage B: output register; data only reloads with a valid beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_inv   <= 1'b0;
    end else if (adv_b) begin
      out_valid <= vld_src;
      if (vld_src) begin
        out_data <= look_res;
        out_inv  <= inv_src;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_done <= '0;
    end else if (out_valid && out_ready) begin
      beats_done <= beats_done + 1'b1;
    end
  end

endmodule

// File: doc/sub_bytes_pipe.md
Name: sub_bytes_pipe

Overview:
Parametrised, pipelined multi-lane AES SubBytes unit. Each accepted beat carries LANES bytes and one mode bit. The unit applies the forward S-box (encrypt) or the inverse S-box (decrypt) to every byte lane in parallel. It sits between the AES round-state datapath and the MixColumns/ShiftRows stages, uses valid/ready handshakes on both sides, and supports full back-pressure.

Parameters:
LANES, 4, number of byte lanes per beat (1..16); data width = 8*LANES
LAT, 2, pipeline latency in cycles (1 or 2); 1 = output register only, 2 = input register plus output register
CNT_W, 16, width of the processed-beat counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat this cycle
in_data  in  8*LANES  input bytes; lane i = in_data[8i+7:8i]
in_inv  in  1  0 = forward S-box, 1 = inverse S-box, per beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output beat
out_data  out  8*LANES  substituted bytes, same lane order
out_inv  out  1  mode bit that travelled with the beat
beats_done  out  CNT_W  count of output handshakes completed

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high: sampled on the rising edge of clk, no asynchronous path.
- Reset values: out_valid=0, out_data=0, out_inv=0, beats_done=0, and all internal stage valid bits = 0. While rst=1, in_ready=0. The first cycle after reset deasserts, in_ready=1.
- Handshakes:
  - A transfer occurs on a rising edge where valid=1 and ready=1.
  - Once out_valid is asserted, out_data and out_inv stay stable until out_ready=1.
  - in_data and in_inv are sampled only on an input transfer.
- Lookup:
  - Forward: the standard FIPS-197 S-box.
  - Inverse: the standard InvS-box.
  - Both are pure functions of a single byte, with identical logic replicated per lane. There is no cross-lane interaction.
  - The mode bit is carried in the pipeline alongside its data, so a mode change between consecutive beats takes effect exactly at the beat boundary with no bubble.
- Pipeline with LAT=2:
  - Stage A registers {in_data, in_inv, vA}; the lookup is computed from stage A.
  - Stage B is the output register {out_data, out_inv, out_valid}.
  - advB = !out_valid | out_ready.
  - advA = !vA | advB.
  - in_ready = advA (combinational from out_ready and state; no combinational path from in_valid).
- Pipeline with LAT=1:
  - The lookup is combinational from in_data and registered into the output register.
  - in_ready = !out_valid | out_ready.
- Stage update rules:
  - When a stage advances, it loads the upstream contents. Its valid bit becomes the upstream valid (or in_valid && in_ready for the first stage).
  - When a stage does not advance, it holds.
  - A bubble never overwrites held valid data.
- Latency and throughput:
  - An input transfer at edge N makes out_valid=1 after edge N+LAT, provided out_ready stayed 1.
  - Sustained throughput is 1 beat/cycle with out_ready=1.
  - Maximum occupancy is LAT beats.
- Full back-pressure:
  - With out_ready=0 and all LAT stages valid, in_ready=0.
  - When out_ready rises, the same cycle shows in_ready=1 (pass-through of ready), and no beat is lost or duplicated.
- Simultaneous events: when an output transfer and an input transfer happen on the same edge with a full pipe, each stage shifts by one.
- beats_done:
  - Increments by 1 on every output transfer (out_valid && out_ready).
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - Holds otherwise.
- Reset mid-operation: rst=1 on any edge discards every in-flight beat. The outputs return to their reset values on that edge, with no partial output and no count update that cycle.
- out_data when out_valid=0 holds its last value. It is don't-care for checking.

Test Plan:
- LAT=2, LANES=4, out_ready=1; in_data=0xFF53_0100, in_inv=0 -> 2 cycles later out_data=0x16ED_7C63, out_valid=1 for one cycle, beats_done=1.
- Same config; in_data=0x1653_7C63, in_inv=1 -> out_data=0xFF50_0100, out_inv=1. Then back-to-back forward beat 0x0000_0000 -> 0x6363_6363 on the next cycle with no bubble.
- Back-pressure: stream 4 beats with out_ready=0 -> exactly 2 accepted and in_ready=0 afterwards, out_data held stable. Raise out_ready -> all 4 outputs emerge in order, none dropped or duplicated, beats_done=4.
- Random valid/ready toggling, 1000 beats, random mode per beat -> scoreboard matches a software S-box/InvS-box model per lane, and beats_done equals the output handshake count.
- rst=1 asserted while 2 beats are in flight -> next cycle out_valid=0, beats_done=0, in_ready=0 during reset and 1 after. Subsequent traffic is correct.
- LAT=1, LANES=1 -> 0x00 forward gives 0x63 after 1 cycle. CNT_W=4 with 17 beats -> beats_done=1 (wrap).
